// File: rtl/pci_phy_pkg.sv
// Shared widths for the PCI physical-layer symbol packing path.
`default_nettype none

package pci_phy_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_RATIO = 4;
    localparam int OUT_W     = DEF_IN_W * DEF_RATIO;
    localparam int IDX_W     = $clog2(DEF_RATIO);

    // Parametrised forms of OUT_W / IDX_W for instances that override the defaults.
    function automatic int word_width(input int in_w, input int ratio);
        return in_w * ratio;
    endfunction

    function automatic int index_width(input int ratio);
        return $clog2(ratio);
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux_word_pack_word_out_reg.sv
// One-entry valid/ready holding register for completed words.
`default_nettype none

module word_out_reg #(
    parameter int W = 32
) (
    input  logic         clk_4f,
    input  logic         reset_L,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready_out,
    output logic         out_full,
    output logic         valid_out,
    output logic [W-1:0] data_out
);

    // data_out is deliberately not cleared on drain; it keeps the last word.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            out_full <= 1'b0;
            data_out <= '0;
        end else if (load) begin
            out_full <= 1'b1;
            data_out <= load_data;
        end else if (ready_out) begin
            out_full <= 1'b0;
        end
    end

    assign valid_out = out_full;

endmodule

`default_nettype wire

// File: rtl/demux_word_pack.sv
// Packs IN_W-bit symbols into IN_W*RATIO-bit words (first symbol in the MSBs)
// with start-of-frame realignment, saturating drop count and ready/valid on both sides.
`default_nettype none

module demux_word_pack
    import pci_phy_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int RATIO = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk_4f,
    input  logic                  reset_L,
    input  logic                  valid_in,
    input  logic [IN_W-1:0]       data_in,
    input  logic                  sof_in,
    output logic                  ready_in,
    output logic                  valid_out,
    output logic [IN_W*RATIO-1:0] data_out,
    input  logic                  ready_out,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int              WORD_W   = word_width(IN_W, RATIO);
    localparam int              SEL_W    = index_width(RATIO);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SEL_W-1:0]  idx;
    logic [SEL_W-1:0]  idx_nxt;
    logic [SEL_W-1:0]  slot;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_nxt;
    logic              out_full;
    logic              at_last;
    logic              accept;
    logic              load;

    always_comb begin
        at_last = (idx == LAST_IDX);
        // A symbol carrying sof is a new symbol 0, so only a true completing symbol can stall.
        ready_in = !(at_last && !(valid_in && sof_in) && out_full && !ready_out);
        accept   = valid_in && ready_in;
        slot     = sof_in ? '0 : idx;
        acc_nxt  = acc;
        acc_nxt[WORD_W-1 - int'(slot)*IN_W -: IN_W] = data_in;
        load     = accept && !sof_in && at_last;
        idx_nxt  = idx;
        if (accept) begin
            if (sof_in)
                idx_nxt = SEL_W'(1);
            else if (at_last)
                idx_nxt = '0;
            else
                idx_nxt = idx + 1'b1;
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            idx      <= '0;
            acc      <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                idx <= idx_nxt;
                acc <= acc_nxt;
            end
            if (accept && sof_in && (idx != '0) && (drop_cnt != CNT_MAX))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    word_out_reg #(
        .W (WORD_W)
    ) u_word_out_reg (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .load      (load),
        .load_data (acc_nxt),
        .ready_out (ready_out),
        .out_full  (out_full),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_demux_word_pack.sv
// Directed scoreboard bench for demux_word_pack (8x4 and 4x8 instances).
`default_nettype none

module tb_demux_word_pack;

    logic        clk_4f  = 1'b0;
    logic        reset_L = 1'b0;

    logic        va = 1'b0, sa = 1'b0, ra = 1'b1;
    logic [7:0]  da = '0;
    logic        rdy_a, vo_a;
    logic [31:0] do_a;
    logic [7:0]  drop_a;

    logic        vb = 1'b0, sb = 1'b0, rb = 1'b1;
    logic [3:0]  db = '0;
    logic        rdy_b, vo_b;
    logic [31:0] do_b;
    logic [1:0]  drop_b;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk_4f = ~clk_4f;

    demux_word_pack dut_a (
        .clk_4f (clk_4f), .reset_L (reset_L),
        .valid_in (va), .data_in (da), .sof_in (sa), .ready_in (rdy_a),
        .valid_out (vo_a), .data_out (do_a), .ready_out (ra), .drop_cnt (drop_a)
    );

    demux_word_pack #(.IN_W(4), .RATIO(8), .CNT_W(2)) dut_b (
        .clk_4f (clk_4f), .reset_L (reset_L),
        .valid_in (vb), .data_in (db), .sof_in (sb), .ready_in (rdy_b),
        .valid_out (vo_b), .data_out (do_b), .ready_out (rb), .drop_cnt (drop_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a word leaves the DUT at each posedge where valid_out && ready_out.
    always @(negedge clk_4f) begin
        if (reset_L && vo_a && ra) begin
            if (qa.size() == 0) chk("a_unexpected_word", do_a, 32'hxxxxxxxx);
            else chk("a_word", do_a, qa.pop_front());
        end
        if (reset_L && vo_b && rb) begin
            if (qb.size() == 0) chk("b_unexpected_word", do_b, 32'hxxxxxxxx);
            else chk("b_word", do_b, qb.pop_front());
        end
    end

    task automatic send(input int which, input logic [7:0] d, input logic s);
        logic done;
        done = 1'b0;
        if (which == 0) begin va = 1'b1; da = d; sa = s; end
        else begin vb = 1'b1; db = d[3:0]; sb = s; end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk_4f);
            done = (which == 0) ? rdy_a : rdy_b;
            @(posedge clk_4f);
            #1;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        if (which == 0) begin va = 1'b0; sa = 1'b0; end
        else begin vb = 1'b0; sb = 1'b0; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_4f);
        #1;
    endtask

    task automatic reset_pulse();
        #3 reset_L = 1'b0;
        #2 reset_L = 1'b1;
        idle(1);
    endtask

    initial begin
        #2;
        chk("rst_valid_out", {31'd0, vo_a}, 32'd0);
        chk("rst_data_out", do_a, 32'd0);
        chk("rst_drop_cnt", {24'd0, drop_a}, 32'd0);
        chk("rst_ready_in", {31'd0, rdy_a}, 32'd1);
        #11 reset_L = 1'b1;
        idle(1);

        // 1: continuous stream, one word then a waiting partial
        qa.push_back(32'hEEFFFDCC);
        send(0, 8'hEE, 0); send(0, 8'hFF, 0); send(0, 8'hFD, 0); send(0, 8'hCC, 0);
        chk("t1_valid_after_cc", {31'd0, vo_a}, 32'd1);
        chk("t1_data_after_cc", do_a, 32'hEEFFFDCC);
        send(0, 8'hAA, 0); send(0, 8'h12, 0); send(0, 8'hBB, 0);
        idle(4);
        chk("t1_partial_no_valid", {31'd0, vo_a}, 32'd0);
        chk("t1_drop_cnt", {24'd0, drop_a}, 32'd0);
        chk("t1_data_held", do_a, 32'hEEFFFDCC);
        reset_pulse();

        // 2: backpressure stalls only the completing symbol
        ra = 1'b0;
        qa.push_back(32'h01020304);
        qa.push_back(32'h05060708);
        for (int i = 1; i <= 7; i++) send(0, 8'(i), 0);
        chk("t2_held_word", do_a, 32'h01020304);
        chk("t2_held_valid", {31'd0, vo_a}, 32'd1);
        va = 1'b1; da = 8'h08;
        @(negedge clk_4f);
        chk("t2_stall_ready_in", {31'd0, rdy_a}, 32'd0);
        @(posedge clk_4f); #1;
        ra = 1'b1;
        @(negedge clk_4f);
        chk("t2_release_ready_in", {31'd0, rdy_a}, 32'd1);
        @(posedge clk_4f); #1;
        va = 1'b0;
        chk("t2_second_word", do_a, 32'h05060708);
        chk("t2_second_valid", {31'd0, vo_a}, 32'd1);
        idle(2);

        // 3: sof realignment drops the partial word
        qa.push_back(32'h33445566);
        send(0, 8'h11, 0); send(0, 8'h22, 0); send(0, 8'h33, 1);
        chk("t3_drop_cnt", {24'd0, drop_a}, 32'd1);
        send(0, 8'h44, 0); send(0, 8'h55, 0); send(0, 8'h66, 0);
        idle(2);

        // 4: gapped input
        qa.push_back(32'hA1A2A3A4);
        send(0, 8'hA1, 0); idle(1); send(0, 8'hA2, 0); idle(1); send(0, 8'hA3, 0); idle(1);
        chk("t4_no_early_valid", {31'd0, vo_a}, 32'd0);
        send(0, 8'hA4, 0);
        idle(2);

        // 5: asynchronous reset mid-word
        ra = 1'b0;
        qa.push_back(32'h9ABCDEF0);
        send(0, 8'h77, 0); send(0, 8'h78, 0);
        #3 reset_L = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, vo_a}, 32'd0);
        chk("t5_async_drop", {24'd0, drop_a}, 32'd0);
        #2 reset_L = 1'b1;
        ra = 1'b1;
        idle(1);
        send(0, 8'h9A, 0); send(0, 8'hBC, 0); send(0, 8'hDE, 0); send(0, 8'hF0, 0);
        idle(2);

        // 6: 4-bit x 8 instance and drop saturation
        qb.push_back(32'h12345678);
        for (int i = 1; i <= 8; i++) send(1, 8'(i), 0);
        idle(2);
        send(1, 8'h0, 1);
        for (int i = 0; i < 5; i++) begin
            send(1, 8'h1, 0);
            send(1, 8'h2, 1);
            if (i == 1) chk("t6_drop_two", {30'd0, drop_b}, 32'd2);
        end
        chk("t6_drop_saturated", {30'd0, drop_b}, 32'd3);
        idle(3);

        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux_word_pack.md
Name: demux_word_pack

Overview:
Parametrised successor of the 8-to-32 demux in the PCI physical-layer path. It packs a stream of IN_W-bit symbols into IN_W*RATIO-bit words, first symbol in the MSBs. New over the fixed 8→32 demux:
- start-of-frame realignment
- partial-word drop counting
- ready/valid backpressure on both sides
It sits between the byte-lane receiver and the word-wide link logic, in the clk_4f domain.

Parameters:
IN_W, 8, input symbol width in bits (>=1)
RATIO, 4, symbols per output word (>=2); output width OUT_W = IN_W*RATIO
CNT_W, 8, width of saturating drop counter

Ports:
clk_4f  in  1  single clock; all logic on posedge
reset_L  in  1  asynchronous, active-low reset
valid_in  in  1  data_in holds a symbol
data_in  in  IN_W  input symbol
sof_in  in  1  qualifies data_in as symbol 0 of a new word (only meaningful with valid_in)
ready_in  out  1  block can accept a symbol this cycle (combinational)
valid_out  out  1  data_out holds a complete word
data_out  out  OUT_W  packed word
ready_out  in  1  downstream accepts data_out this cycle
drop_cnt  out  CNT_W  count of discarded partial words, saturating

Behaviour:
- Reset is asynchronous and active-low. While reset_L=0:
  - idx=0, accumulator=0, out_full=0.
  - valid_out=0, data_out=0, drop_cnt=0.
  - ready_in=1, because it is combinational and out_full=0.
- Accept: a symbol is accepted at a posedge when valid_in && ready_in. With valid_in=0 all state holds; there is no timeout, so a partial word waits indefinitely.
- Placement: the symbol accepted at index k (0..RATIO-1) goes to bits [OUT_W-1-k*IN_W -: IN_W].
- Index counter: idx is $clog2(RATIO) bits. It increments per accept and wraps from RATIO-1 to 0.
- sof_in=1 on an accepted symbol:
  - The symbol is written at index 0 and idx becomes 1.
  - If idx!=0 at that moment, the partial word is discarded and drop_cnt increments, saturating at 2^CNT_W-1.
  - If idx==0, sof has no extra effect.
- Word completion: accepting the symbol at idx==RATIO-1 loads the completed word into the output register.
  - data_out and valid_out update at that same posedge, so the word is visible one cycle after the last symbol is presented.
  - Unused accumulator bits are not cleared; every word fully overwrites them.
- Output handshake:
  - valid_out stays high until a posedge with ready_out=1.
  - data_out holds its last value after the drain; it is not cleared.
  - Drain and new load in the same posedge: valid_out stays 1 and data_out takes the new word.
- ready_in = !(idx==RATIO-1 && out_full && !ready_out).
  - Symbols 0..RATIO-2 are always accepted.
  - Only the completing symbol stalls.
  - A completing symbol that carries sof_in is a new symbol 0, so it is never stalled.
- Arithmetic: drop_cnt uses unsigned saturating increment; there is no other arithmetic.

Decomposition:
- Shared package pci_phy_pkg holds localparams OUT_W = IN_W*RATIO and IDX_W = $clog2(RATIO).
- One sub-module, word_out_reg: a 1-entry valid/ready holding register of width OUT_W, providing out_full, valid_out and data_out.
- Packing, index and drop counter stay in the top module.

Test Plan:
1. Continuous stream EE,FF,FD,CC,AA,12,BB with ready_out=1 → one valid_out pulse with data_out=32'hEEFFFDCC, one cycle after CC is accepted. AA,12,BB remain partial; valid_out stays 0 and drop_cnt=0.
2. ready_out=0, stream 01..08 → word 32'h01020304 held. 05,06,07 are accepted. ready_in=0 while 08 is presented. Raising ready_out: 08 is accepted in that cycle, then valid_out with 32'h05060708.
3. Stream 11,22, then 33 with sof_in=1, then 44,55,66 → drop_cnt=1, single word 32'h33445566.
4. valid_in asserted every other cycle with A1,A2,A3,A4 → 32'hA1A2A3A4. No output before the fourth accept.
5. Reset mid-operation: after 2 symbols, pulse reset_L low asynchronously (not aligned to clk_4f) → valid_out=0 and drop_cnt=0 immediately. The next 4 symbols 9A,BC,DE,F0 give 32'h9ABCDEF0.
6. Instance with IN_W=4, RATIO=8, CNT_W=2 → nibbles 1..8 give 32'h12345678. Five sof-forced drops give drop_cnt=3 (saturated).
